// File: rtl/music_box_state_sequencer.sv
// Music box state sequencer.
// Collects debounced button presses and grants them one at a time, round-robin,
// as a play state broadcast on currentState. Each grant runs until its state
// module reports completion, the same button is pressed again (abort), or the
// millisecond watchdog expires. A cooldown of at least two 1 kHz ticks with
// DoNothing on the bus follows every grant, so slow state modules can clear.
module music_box_state_sequencer #(
    parameter int NUM_STATES = 4,
    parameter int TIMEOUT_MS = 10000
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset_n,
    input  logic                  tick_1Khz,
    input  logic [NUM_STATES-1:0] buttonRequest,
    input  logic [NUM_STATES-1:0] stateComplete,
    output logic [4:0]            currentState,
    output logic                  busy,
    output logic                  timeoutFlag,
    output logic [31:0]           debugString
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_MS);
    localparam logic [15:0] MS_MAX        = 16'hFFFF;
    localparam logic [2:0]  LAST_IDX      = 3'(NUM_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACTIVE   = 2'b01,
        ST_COOLDOWN = 2'b10,
        ST_ILLEGAL  = 2'b11
    } fsm_t;

    fsm_t        state_r;
    logic [7:0]  btn_ext_s;
    logic [7:0]  cmp_ext_s;
    logic [7:0]  btn_hist_r;
    logic [7:0]  rise_s;
    logic [7:0]  pending_r;
    logic [7:0]  grant_mask_s;
    logic [7:0]  active_mask_s;
    logic [3:0]  pick_s;
    logic [2:0]  grant_idx_s;
    logic        grant_valid_s;
    logic [2:0]  rr_ptr_r;
    logic [2:0]  active_idx_r;
    logic [15:0] ms_counter_r;
    logic [1:0]  cool_ticks_r;
    logic [4:0]  current_state_r;
    logic        busy_r;
    logic        timeout_flag_r;
    logic        complete_s;
    logic        abort_s;
    logic        timeout_s;

    // Round-robin pick: first requesting index at or after ptr, wrapping at NUM_STATES.
    // Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [3:0] pick;
        int         idx;
        pick = 4'd0;
        for (int k = NUM_STATES - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_STATES) begin
                idx = idx - NUM_STATES;
            end else begin
                idx = idx;
            end
            if (req[3'(idx)]) begin
                pick = {1'b1, 3'(idx)};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Widen the button and completion buses to a fixed 8 bits so a 3-bit index always fits.
    always_comb begin
        btn_ext_s = 8'd0;
        cmp_ext_s = 8'd0;
        for (int i = 0; i < NUM_STATES; i++) begin
            btn_ext_s[i] = buttonRequest[i];
            cmp_ext_s[i] = stateComplete[i];
        end
    end

    assign rise_s        = btn_ext_s & ~btn_hist_r;
    assign pick_s        = rr_pick(pending_r | rise_s, rr_ptr_r);
    assign grant_idx_s   = pick_s[2:0];
    assign grant_valid_s = (pending_r != 8'd0) && pick_s[3];
    assign grant_mask_s  = 8'd1 << grant_idx_s;
    assign active_mask_s = 8'd1 << active_idx_r;
    assign complete_s    = cmp_ext_s[active_idx_r];
    assign abort_s       = rise_s[active_idx_r];
    assign timeout_s     = (ms_counter_r >= TIMEOUT_LIMIT);

    // Button history for rising-edge detection; cleared by reset so a held button re-fires once.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            btn_hist_r <= 8'd0;
        end else begin
            btn_hist_r <= btn_ext_s;
        end
    end

    // Sequencer FSM with its pending set, round-robin pointer, counters and registered outputs.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            pending_r       <= 8'd0;
            rr_ptr_r        <= 3'd0;
            active_idx_r    <= 3'd0;
            ms_counter_r    <= 16'd0;
            cool_ticks_r    <= 2'd0;
            current_state_r <= 5'd0;
            busy_r          <= 1'b0;
            timeout_flag_r  <= 1'b0;
        end else begin
            timeout_flag_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ms_counter_r    <= 16'd0;
                    current_state_r <= 5'd0;
                    if (grant_valid_s) begin
                        pending_r       <= (pending_r | rise_s) & ~grant_mask_s;
                        rr_ptr_r        <= (grant_idx_s == LAST_IDX) ? 3'd0 : grant_idx_s + 3'd1;
                        active_idx_r    <= grant_idx_s;
                        current_state_r <= {2'b00, grant_idx_s} + 5'd1;
                        busy_r          <= 1'b1;
                        state_r         <= ST_ACTIVE;
                    end else begin
                        pending_r <= pending_r | rise_s;
                        busy_r    <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    // A press of the active button is an abort, never a new request.
                    pending_r <= pending_r | (rise_s & ~active_mask_s);
                    if (complete_s || abort_s || timeout_s) begin
                        state_r         <= ST_COOLDOWN;
                        current_state_r <= 5'd0;
                        ms_counter_r    <= 16'd0;
                        cool_ticks_r    <= 2'd0;
                        timeout_flag_r  <= !complete_s && !abort_s;
                    end else if (tick_1Khz && (ms_counter_r != MS_MAX)) begin
                        ms_counter_r <= ms_counter_r + 16'd1;
                    end else begin
                        ms_counter_r <= ms_counter_r;
                    end
                end
                ST_COOLDOWN: begin
                    pending_r       <= pending_r | rise_s;
                    current_state_r <= 5'd0;
                    ms_counter_r    <= 16'd0;
                    if (tick_1Khz && (cool_ticks_r != 2'd2)) begin
                        cool_ticks_r <= cool_ticks_r + 2'd1;
                    end else begin
                        cool_ticks_r <= cool_ticks_r;
                    end
                    if ((cool_ticks_r == 2'd2) && !complete_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_COOLDOWN;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    current_state_r <= 5'd0;
                    ms_counter_r    <= 16'd0;
                    cool_ticks_r    <= 2'd0;
                    busy_r          <= 1'b0;
                end
            endcase
        end
    end

    assign currentState = current_state_r;
    assign busy         = busy_r;
    assign timeoutFlag  = timeout_flag_r;
    assign debugString  = {3'b000, current_state_r, 6'b000000, 2'(state_r), ms_counter_r};

endmodule

// File: tb/tb_music_box_state_sequencer.sv
// Testbench for music_box_state_sequencer: directed scenarios plus a randomized
// run checked every cycle against a behavioural model of the sequencing rules.
module tb_music_box_state_sequencer;

    localparam int NS = 4;
    localparam int TO = 20;

    logic        clock_50Mhz = 1'b0;
    logic        reset_n;
    logic        tick_1Khz;
    logic [3:0]  buttonRequest;
    logic [3:0]  stateComplete;
    logic [4:0]  currentState;
    logic        busy;
    logic        timeoutFlag;
    logic [31:0] debugString;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state: mode 0 idle, 1 playing, 2 cooling down.
    int m_mode, m_ptr, m_active, m_ms, m_cool, m_cur;
    bit m_busy, m_to;
    bit m_pend[NS];
    bit m_prev[NS];

    always #5 clock_50Mhz = ~clock_50Mhz;

    music_box_state_sequencer #(.NUM_STATES(NS), .TIMEOUT_MS(TO)) dut (
        .clock_50Mhz  (clock_50Mhz),
        .reset_n      (reset_n),
        .tick_1Khz    (tick_1Khz),
        .buttonRequest(buttonRequest),
        .stateComplete(stateComplete),
        .currentState (currentState),
        .busy         (busy),
        .timeoutFlag  (timeoutFlag),
        .debugString  (debugString)
    );

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_active = 0; m_ms = 0; m_cool = 0; m_cur = 0;
        m_busy = 1'b0; m_to = 1'b0;
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 1'b0;
            m_prev[i] = 1'b0;
        end
    endtask

    // One clock of the sequencing rules, evaluated from the values seen at the edge.
    task automatic model_update(input logic [3:0] b, input logic [3:0] c, input logic t);
        bit rise[NS];
        bit any;
        int g;
        int j;
        for (int i = 0; i < NS; i++) rise[i] = b[i] && !m_prev[i];
        m_to = 1'b0;
        if (m_mode == 0) begin
            any = 1'b0;
            for (int i = 0; i < NS; i++) if (m_pend[i]) any = 1'b1;
            g = -1;
            if (any) begin
                for (int k = 0; k < NS; k++) begin
                    j = (m_ptr + k) % NS;
                    if (g < 0 && (m_pend[j] || rise[j])) g = j;
                end
            end
            for (int i = 0; i < NS; i++) if (rise[i]) m_pend[i] = 1'b1;
            if (g >= 0) begin
                m_pend[g] = 1'b0;
                m_ptr = (g + 1) % NS;
                m_active = g;
                m_cur = g + 1;
                m_ms = 0;
                m_mode = 1;
                m_busy = 1'b1;
            end
        end else if (m_mode == 1) begin
            for (int i = 0; i < NS; i++) if (rise[i] && i != m_active) m_pend[i] = 1'b1;
            if (c[m_active] || rise[m_active] || m_ms >= TO) begin
                m_to = !c[m_active] && !rise[m_active];
                m_mode = 2; m_cur = 0; m_ms = 0; m_cool = 0;
            end else if (t && m_ms < 65535) begin
                m_ms++;
            end
        end else begin
            for (int i = 0; i < NS; i++) if (rise[i]) m_pend[i] = 1'b1;
            if (m_cool >= 2 && !c[m_active]) begin
                m_mode = 0;
                m_busy = 1'b0;
            end else if (t && m_cool < 2) begin
                m_cool++;
            end
        end
        for (int i = 0; i < NS; i++) m_prev[i] = b[i];
    endtask

    // Drive one cycle of inputs, let an edge happen, advance the model, settle for sampling.
    task automatic cycle(input logic [3:0] b, input logic [3:0] c, input logic t);
        buttonRequest = b;
        stateComplete = c;
        tick_1Khz     = t;
        @(posedge clock_50Mhz);
        model_update(b, c, t);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] b);
        reset_n       = 1'b0;
        buttonRequest = b;
        stateComplete = 4'd0;
        tick_1Khz     = 1'b0;
        repeat (2) @(posedge clock_50Mhz);
        #1;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        buttonRequest = 4'b0010;
        stateComplete = 4'd0;
        tick_1Khz     = 1'b0;
        repeat (2) @(posedge clock_50Mhz);
        #1;
        tests_run++;
        if ({currentState, busy, timeoutFlag, debugString} !== 39'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got cs=%0d busy=%0b to=%0b dbg=%08h expected all zero",
                     currentState, busy, timeoutFlag, debugString);
        end
        model_reset();
        reset_n = 1'b1;
        cycle(4'b0010, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_at_release_edge1: got cs=%0d busy=%0b expected 0 0", currentState, busy);
        end
        cycle(4'b0010, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd2 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL held_at_release_grant: got cs=%0d busy=%0b expected 2 1", currentState, busy);
        end
    endtask

    task automatic test_single_request();
        do_reset(4'd0);
        cycle(4'b0001, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd0) begin
            tests_failed++;
            $display("FAIL single_edge1: got cs=%0d expected 0", currentState);
        end
        cycle(4'b0000, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: got cs=%0d busy=%0b expected 1 1", currentState, busy);
        end
        cycle(4'b0000, 4'd0, 1'b1);
        cycle(4'b0000, 4'b0001, 1'b0);
        tests_run++;
        if (currentState !== 5'd0 || busy !== 1'b1 || debugString[17:16] !== 2'b10 || debugString[15:0] !== 16'd0) begin
            tests_failed++;
            $display("FAIL single_complete: got cs=%0d busy=%0b dbg=%08h expected 0 1 fsm=2 ms=0",
                     currentState, busy, debugString);
        end
        cycle(4'b0000, 4'b0001, 1'b1);
        cycle(4'b0000, 4'b0001, 1'b1);
        cycle(4'b0000, 4'b0001, 1'b0);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_cool_hold: got busy=%0b expected 1 while complete high", busy);
        end
        cycle(4'b0000, 4'b0000, 1'b0);
        tests_run++;
        if (busy !== 1'b0 || debugString !== 32'd0) begin
            tests_failed++;
            $display("FAIL single_idle: got busy=%0b dbg=%08h expected 0 0", busy, debugString);
        end
    endtask

    task automatic test_held_button();
        int grants;
        logic [4:0] prev_cur;
        do_reset(4'd0);
        grants   = 0;
        prev_cur = 5'd0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            cycle(4'b0001, (cyc == 30) ? 4'b0001 : 4'b0000, (cyc % 4) == 3);
            if (prev_cur == 5'd0 && currentState != 5'd0) grants++;
            prev_cur = currentState;
        end
        cycle(4'b0000, 4'd0, 1'b0);
        tests_run++;
        if (grants != 1) begin
            tests_failed++;
            $display("FAIL held_grant_count: got %0d expected 1", grants);
        end
        tests_run++;
        if (currentState !== 5'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_final: got cs=%0d busy=%0b expected 0 0", currentState, busy);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[3] = '{1, 2, 4};
        int w;
        logic [3:0] mask;
        do_reset(4'd0);
        cycle(4'b1011, 4'd0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            w = 0;
            while (currentState == 5'd0 && w < 10) begin
                cycle(4'b1011, 4'd0, 1'b0);
                w++;
            end
            tests_run++;
            if (currentState !== 5'(exp_seq[s]) || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got cs=%0d busy=%0b expected %0d 1", s, currentState, busy, exp_seq[s]);
            end
            mask = 4'b0001 << (exp_seq[s] - 1);
            cycle(4'b1011, mask, 1'b0);
            tests_run++;
            if (currentState !== 5'd0 || debugString[17:16] !== 2'b10) begin
                tests_failed++;
                $display("FAIL rr_cool%0d: got cs=%0d fsm=%0d expected 0 2", s, currentState, debugString[17:16]);
            end
            cycle(4'b1011, 4'd0, 1'b1);
            cycle(4'b1011, 4'd0, 1'b1);
            cycle(4'b1011, 4'd0, 1'b0);
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_idle%0d: got busy=%0b expected 0", s, busy);
            end
        end
        repeat (3) cycle(4'b1011, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd0) begin
            tests_failed++;
            $display("FAIL rr_drained: got cs=%0d expected 0", currentState);
        end
    endtask

    task automatic test_watchdog();
        bit bad;
        do_reset(4'd0);
        cycle(4'b0001, 4'd0, 1'b0);
        cycle(4'b0001, 4'd0, 1'b0);
        bad = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            cycle(4'b0001, 4'd0, 1'b1);
            if (currentState !== 5'd1 || timeoutFlag !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad || debugString[15:0] !== 16'd20) begin
            tests_failed++;
            $display("FAIL wd_count: got early_exit=%0b ms=%0d expected 0 20", bad, debugString[15:0]);
        end
        cycle(4'b0001, 4'd0, 1'b0);
        tests_run++;
        if (timeoutFlag !== 1'b1 || currentState !== 5'd0 || debugString[17:16] !== 2'b10) begin
            tests_failed++;
            $display("FAIL wd_expire: got to=%0b cs=%0d fsm=%0d expected 1 0 2",
                     timeoutFlag, currentState, debugString[17:16]);
        end
        cycle(4'b0001, 4'd0, 1'b0);
        tests_run++;
        if (timeoutFlag !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_pulse_width: got to=%0b expected 0", timeoutFlag);
        end
    endtask

    task automatic test_abort_with_complete();
        do_reset(4'd0);
        cycle(4'b0100, 4'd0, 1'b0);
        cycle(4'b0000, 4'd0, 1'b0);
        cycle(4'b0000, 4'd0, 1'b0);
        cycle(4'b0100, 4'b0100, 1'b0);
        tests_run++;
        if (currentState !== 5'd0 || timeoutFlag !== 1'b0 || debugString[17:16] !== 2'b10) begin
            tests_failed++;
            $display("FAIL abort_complete: got cs=%0d to=%0b fsm=%0d expected 0 0 2",
                     currentState, timeoutFlag, debugString[17:16]);
        end
        cycle(4'b0100, 4'd0, 1'b1);
        cycle(4'b0100, 4'd0, 1'b1);
        cycle(4'b0100, 4'd0, 1'b0);
        repeat (3) cycle(4'b0100, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_pending: got cs=%0d busy=%0b expected 0 0", currentState, busy);
        end
        cycle(4'b0000, 4'd0, 1'b0);
        cycle(4'b0100, 4'd0, 1'b0);
        cycle(4'b0000, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd3) begin
            tests_failed++;
            $display("FAIL abort_regrant: got cs=%0d expected 3", currentState);
        end
        cycle(4'b0100, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd0 || timeoutFlag !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_only: got cs=%0d to=%0b busy=%0b expected 0 0 1", currentState, timeoutFlag, busy);
        end
        cycle(4'b0000, 4'd0, 1'b1);
        cycle(4'b0000, 4'd0, 1'b1);
        repeat (3) cycle(4'b0000, 4'd0, 1'b0);
        tests_run++;
        if (currentState !== 5'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_only_idle: got cs=%0d busy=%0b expected 0 0", currentState, busy);
        end
    endtask

    task automatic test_reset_mid_active();
        bit bad;
        do_reset(4'd0);
        cycle(4'b0001, 4'd0, 1'b0);
        cycle(4'b0001, 4'd0, 1'b0);
        for (int k = 0; k < 7; k++) cycle((k == 3) ? 4'b0011 : 4'b0001, 4'd0, 1'b1);
        tests_run++;
        if (currentState !== 5'd1 || debugString[15:0] !== 16'd7) begin
            tests_failed++;
            $display("FAIL mid_setup: got cs=%0d ms=%0d expected 1 7", currentState, debugString[15:0]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({currentState, busy, timeoutFlag, debugString} !== 39'd0) begin
            tests_failed++;
            $display("FAIL mid_async_reset: got cs=%0d busy=%0b to=%0b dbg=%08h expected all zero",
                     currentState, busy, timeoutFlag, debugString);
        end
        buttonRequest = 4'd0;
        @(posedge clock_50Mhz);
        #1;
        model_reset();
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            cycle(4'b0000, 4'd0, 1'b0);
            if (currentState !== 5'd0 || busy !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL mid_pending_lost: got a grant after reset, expected none (cs=%0d)", currentState);
        end
    endtask

    task automatic test_random();
        logic [3:0]  b;
        logic [3:0]  c;
        logic        t;
        logic [31:0] exp_dbg;
        do_reset(4'd0);
        b = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 31) == 0) b[i] = ~b[i];
                c[i] = ($urandom_range(0, 39) == 0);
            end
            t = ($urandom_range(0, 5) == 0);
            cycle(b, c, t);
            exp_dbg = {3'b000, 5'(m_cur), 6'b000000, 2'(m_mode), 16'(m_ms)};
            tests_run++;
            if (currentState !== 5'(m_cur) || busy !== m_busy || timeoutFlag !== m_to || debugString !== exp_dbg) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got cs=%0d busy=%0b to=%0b dbg=%08h expected cs=%0d busy=%0b to=%0b dbg=%08h",
                         n, currentState, busy, timeoutFlag, debugString, m_cur, m_busy, m_to, exp_dbg);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_request();
        test_held_button();
        test_round_robin();
        test_watchdog();
        test_abort_with_complete();
        test_reset_mid_active();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
